// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit (NOT/AND/OR/XOR) with valid/ready on both sides.
// Optional parity output enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid of the same side, and a stalled
    // output (out_valid=1, out_ready=0) keeps y/zero/parity stable.

    logic [WIDTH-1:0]  res_c;
    logic              zero_c;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] z_r;
    logic [WIDTH-1:0]  y_r [STAGES];
    logic              full_tail;
`ifdef LOGIC_UNIT_PARITY_EN
    logic              parity_c;
    logic [STAGES-1:0] p_r;
`endif

    always_comb begin
        res_c = '0;
        case (op)
            2'b00: res_c = ~a;
            2'b01: res_c = a & b;
            2'b10: res_c = a | b;
            2'b11: res_c = a ^ b;
            default: res_c = '0;
        endcase
    end

    assign zero_c = (res_c == '0);
`ifdef LOGIC_UNIT_PARITY_EN
    assign parity_c = ^res_c;
`endif

    // en[i] = !v[i] || en[i+1] unrolled: a stage may load unless it and every
    // stage behind it are full while the consumer stalls.
    always_comb begin
        full_tail = 1'b1;
        en        = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_tail = full_tail & v[i];
            en[i]     = !full_tail || out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            z_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                y_r[i] <= '0;
            end
`ifdef LOGIC_UNIT_PARITY_EN
            p_r <= '0;
`endif
        end else begin
            if (en[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    y_r[0] <= res_c;
                    z_r[0] <= zero_c;
`ifdef LOGIC_UNIT_PARITY_EN
                    p_r[0] <= parity_c;
`endif
                end
            end
            // Data only moves with a valid token so idle outputs stay quiet.
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        y_r[i] <= y_r[i-1];
                        z_r[i] <= z_r[i-1];
`ifdef LOGIC_UNIT_PARITY_EN
                        p_r[i] <= p_r[i-1];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[STAGES-1];
    assign y         = y_r[STAGES-1];
    assign zero      = z_r[STAGES-1];
`ifdef LOGIC_UNIT_PARITY_EN
    assign parity    = p_r[STAGES-1];
`endif

endmodule
